// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, requests words from instruction memory,
// and buffers PC-tagged responses in a small FIFO toward decode.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam logic STATE_BOOT = 1'b0;
  localparam logic STATE_RUN  = 1'b1;

  logic        state;
  logic [31:0] pc;
  logic [31:0] rsp_pc;
  logic [3:0]  out_cnt;
  logic [3:0]  drop_cnt;
  logic [3:0]  count;
  logic [2:0]  wr_ptr;
  logic [2:0]  rd_ptr;
  logic [31:0] data_mem [8];
  logic [31:0] pc_mem   [8];

  logic [4:0]  credit;
  logic        req_fire;
  logic        push;
  logic        pop;
  logic [31:0] redirect_word_pc;

  function automatic logic [2:0] next_ptr(input logic [2:0] p);
    return (p == 3'(FIFO_DEPTH - 1)) ? 3'd0 : p + 3'd1;
  endfunction

  // Outstanding requests, pending drops and buffered words all share one budget,
  // so every accepted response is guaranteed a FIFO slot.
  assign credit           = 5'(out_cnt) + 5'(drop_cnt) + 5'(count);
  assign imem_req_valid   = (state == STATE_RUN) && !redirect_valid && (credit < 5'(FIFO_DEPTH));
  assign imem_addr        = pc;
  assign req_fire         = imem_req_valid && imem_req_ready;
  assign push             = imem_rsp_valid && (drop_cnt == 4'd0) && !redirect_valid;
  assign instr_valid      = (count != 4'd0) && !redirect_valid;
  assign pop              = instr_valid && instr_ready;
  assign instr            = data_mem[rd_ptr];
  assign instr_pc         = pc_mem[rd_ptr];
  assign redirect_word_pc = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STATE_BOOT;
    end else begin
      state <= STATE_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      rsp_pc   <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (redirect_valid) begin
      // Everything still in flight becomes stale; a response landing this
      // cycle is already discarded, so it is not counted again.
      pc       <= redirect_word_pc;
      rsp_pc   <= redirect_word_pc;
      drop_cnt <= out_cnt + drop_cnt - (imem_rsp_valid ? 4'd1 : 4'd0);
      out_cnt  <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (req_fire) begin
        pc <= pc + 32'd4;
      end
      if (imem_rsp_valid && (drop_cnt != 4'd0)) begin
        drop_cnt <= drop_cnt - 4'd1;
      end
      if (push) begin
        data_mem[wr_ptr] <= imem_rsp_data;
        pc_mem[wr_ptr]   <= rsp_pc;
        rsp_pc           <= rsp_pc + 32'd4;
        wr_ptr           <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      out_cnt <= out_cnt + {3'b000, req_fire} - {3'b000, push};
      count   <= count + {3'b000, push} - {3'b000, pop};
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: in-order memory model, randomized handshakes
// and redirects, plus a second instance for PC wrap and asynchronous reset.
module tb_instr_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  logic        rst_w_n;
  logic        w_req_valid;
  logic        w_req_ready;
  logic [31:0] w_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_instr_valid;
  logic        w_instr_ready;
  logic [31:0] w_instr;
  logic [31:0] w_instr_pc;

  instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(4)) dut_w (
    .clk(clk), .rst_n(rst_w_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_addr(w_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instr(w_instr), .instr_pc(w_instr_pc)
  );

  typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;
  typedef struct { int unsigned due; logic [31:0] addr; } mreq_t;

  exp_t        exp_q[$];
  mreq_t       mq[$];
  logic [31:0] w_addrs[$];
  int unsigned cyc = 0;
  int unsigned last_due = 0;
  int unsigned n_req = 0;
  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned lat = 1;
  bit          rand_lat = 1'b0;
  logic [31:0] model_pc = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Instruction memory: in-order responses, one per accepted request.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin : mem_proc
      mreq_t m;
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        mq.delete();
        imem_rsp_valid = 1'b0;
      end else if (mq.size() != 0 && mq[0].due <= cyc) begin
        m = mq.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(m.addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
    end
  end

  // Reference model: the fetch stream is a linear PC walk restarted at each redirect.
  initial begin
    forever begin : model_proc
      int unsigned d;
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        model_pc = 32'h0;
        last_due = 0;
      end else if (redirect_valid) begin
        check("redirect_gates_req", 32'(imem_req_valid), 32'd0);
        check("redirect_gates_instr", 32'(instr_valid), 32'd0);
        exp_q.delete();
        model_pc = {redirect_pc[31:2], 2'b00};
      end else if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_addr, model_pc);
        exp_q.push_back('{pc: model_pc, word: mem_word(model_pc)});
        d = cyc + (rand_lat ? $urandom_range(4, 1) : lat);
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        mq.push_back('{due: d, addr: imem_addr});
        model_pc = model_pc + 32'd4;
        n_req++;
      end
    end
  end

  // Monitor: every word handed to decode must match the scoreboard head.
  initial begin
    forever begin : mon_proc
      exp_t e;
      @(negedge clk);
      if (rst_n && instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_instr: got pc %h word %h, expected nothing", instr_pc, instr);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", instr_pc, e.pc);
          check("instr", instr, e.word);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_w_n && w_req_valid && w_req_ready) w_addrs.push_back(w_addr);
    end
  end

  initial begin : stim
    int unsigned base;
    rst_n = 1'b0; rst_w_n = 1'b0;
    imem_req_ready = 1'b1; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    w_req_ready = 1'b1; w_rsp_valid = 1'b0; w_rsp_data = '0;
    w_redirect_valid = 1'b0; w_redirect_pc = '0; w_instr_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);

    @(posedge clk); #1 rst_n = 1'b1;
    check("boot_no_req", 32'(imem_req_valid), 32'd0);
    base = n_req;
    @(posedge clk); #1;
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_addr", imem_addr, 32'h0);

    // Decode held off: the credit rule caps fetch at FIFO_DEPTH words.
    repeat (10) @(posedge clk);
    #1;
    check("bp_req_count", 32'(n_req - base), 32'd4);
    check("bp_req_valid", 32'(imem_req_valid), 32'd0);

    imem_req_ready = 1'b0; instr_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_addr", imem_addr, 32'h10);
    end
    check("stall_req_valid", 32'(imem_req_valid), 32'd1);
    check("stall_no_accept", 32'(n_req - base), 32'd4);

    @(posedge clk); #1 imem_req_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1 lat = 3;
    repeat (6) @(posedge clk);
    #1 redirect_valid = 1'b1; redirect_pc = 32'h203;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_req_valid", 32'(imem_req_valid), 32'd1);
    check("redir_addr", imem_addr, 32'h200);
    repeat (20) @(posedge clk);

    #1 rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      imem_req_ready = ($urandom_range(3, 0) != 0);
      instr_ready    = ($urandom_range(9, 0) < 7);
      if (redirect_valid) redirect_valid = ($urandom_range(3, 0) == 0);
      else                redirect_valid = ($urandom_range(24, 0) == 0);
      redirect_pc = $urandom;
    end

    @(posedge clk); #1;
    redirect_valid = 1'b0; imem_req_ready = 1'b0; instr_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("drain_mem_empty", 32'(mq.size()), 32'd0);
    check("drain_instr_valid", 32'(instr_valid), 32'd0);

    // Wrap instance: first fetch at 0xFFFF_FFFC, second at 0x0.
    @(posedge clk); #1 rst_w_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("wrap_accepts", 32'(w_addrs.size()), 32'd2);
    if (w_addrs.size() >= 2) begin
      check("wrap_first_addr", w_addrs[0], 32'hFFFF_FFFC);
      check("wrap_second_addr", w_addrs[1], 32'h0);
    end
    check("wrap_mid_req_valid", 32'(w_req_valid), 32'd1);
    check("wrap_mid_addr", w_addr, 32'h4);
    #1 rst_w_n = 1'b0;
    #1;
    check("async_rst_req_valid", 32'(w_req_valid), 32'd0);
    check("async_rst_addr", w_addr, 32'hFFFF_FFFC);
    check("async_rst_instr_valid", 32'(w_instr_valid), 32'd0);
    check("async_rst_instr", w_instr, 32'h0);
    check("async_rst_instr_pc", w_instr_pc, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
